// File: rtl/nand4_operand_loader.sv
// Serial operand loader: collects a 4-bit A and 4-bit B operand (LSB first),
// optionally checks an even-parity bit, then presents the pair to a
// downstream 4-bit NAND stage with a valid/ready handshake.
module nand4_operand_loader #(
    parameter int unsigned PARITY_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic       ser_ready,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = 2;

    localparam logic [1:0] LOAD_A = 2'b00;
    localparam logic [1:0] LOAD_B = 2'b01;
    localparam logic [1:0] PARITY = 2'b10;
    localparam logic [1:0] HOLD   = 2'b11;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [BIT_W-1:0] bit_cnt;
    logic [OP_W-1:0]  sh_a;
    logic [OP_W-1:0]  sh_b;
    logic [OP_W-1:0]  b_load;
    logic             xfer;
    logic             last_bit;
    logic             parity_ok;
    logic             load_hold;
    logic             err_next;
    logic             handshake;

    // Ready is a pure state decode, forced low while reset is held
    assign ser_ready = ~rst & (state != HOLD);
    assign xfer      = ser_valid & ser_ready;
    assign last_bit  = (bit_cnt == BIT_W'(3));
    assign parity_ok = ~(^{sh_a, sh_b, ser_in});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus datapath strobes
    always_comb begin
        next_state = state;
        load_hold  = 1'b0;
        err_next   = 1'b0;
        handshake  = 1'b0;
        // Without parity the final B bit is still in flight when HOLD is entered
        b_load     = (state == LOAD_B) ? {ser_in, sh_b[OP_W-1:1]} : sh_b;
        case (state)
            LOAD_A: begin
                if (xfer && last_bit) begin
                    next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (xfer && last_bit) begin
                    if (PARITY_EN != 0) begin
                        next_state = PARITY;
                    end else begin
                        next_state = HOLD;
                        load_hold  = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (xfer) begin
                    if (parity_ok) begin
                        next_state = HOLD;
                        load_hold  = 1'b1;
                    end else begin
                        next_state = LOAD_A;
                        err_next   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (op_ready) begin
                    next_state = LOAD_A;
                    handshake  = 1'b1;
                end
            end
            default: begin
                next_state = LOAD_A;
            end
        endcase
    end

    // Shift registers, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            a_out     <= '0;
            b_out     <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (xfer && (state == LOAD_A)) begin
                sh_a    <= {ser_in, sh_a[OP_W-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (xfer && (state == LOAD_B)) begin
                sh_b    <= {ser_in, sh_b[OP_W-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (load_hold) begin
                a_out <= sh_a;
                b_out <= b_load;
            end
            op_valid  <= (next_state == HOLD);
            frame_err <= err_next;
            if (handshake) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
